// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and FSM state type for the sequential ALU
package alu_pkg;

    // Instruction code field value that marks an executable ALU instruction
    localparam logic [1:0] CODE_ARM    = 2'b11;

    // OP field encodings
    localparam logic [2:0] OP_ADD      = 3'b000;
    localparam logic [2:0] OP_SUB      = 3'b001;
    localparam logic [2:0] OP_MOV      = 3'b010;
    localparam logic [2:0] OP_XSR      = 3'b011;
    localparam logic [2:0] OP_MUL      = 3'b100;
    localparam logic [2:0] OP_AND      = 3'b101;
    localparam logic [2:0] OP_OR       = 3'b110;
    localparam logic [2:0] OP_RSV      = 3'b111;

    // CIN field encodings
    localparam logic [1:0] CIN_ZERO    = 2'b00;
    localparam logic [1:0] CIN_ONE     = 2'b01;
    localparam logic [1:0] CIN_CARRY   = 2'b10;
    localparam logic [1:0] CIN_MSB     = 2'b11;

    // COND field encodings; every 1xxx value means never
    localparam logic [3:0] COND_NEVER  = 4'b0000;
    localparam logic [3:0] COND_ALWAYS = 4'b0001;
    localparam logic [3:0] COND_CS     = 4'b0010;
    localparam logic [3:0] COND_CC     = 4'b0011;
    localparam logic [3:0] COND_EQ     = 4'b0100;
    localparam logic [3:0] COND_NE     = 4'b0101;
    localparam logic [3:0] COND_MI     = 4'b0110;
    localparam logic [3:0] COND_PL     = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cond_eval.sv
// rtl/alu_cond_eval.sv - combinational COND evaluator on a result and its carry-out
module alu_cond_eval
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_out,
    output logic             cond_true
);

    // Decode the condition against the freshly produced result and carry-out
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_NEVER:  cond_true = 1'b0;
            COND_ALWAYS: cond_true = 1'b1;
            COND_CS:     cond_true = carry_out;
            COND_CC:     cond_true = ~carry_out;
            COND_EQ:     cond_true = (result == '0);
            COND_NE:     cond_true = (result != '0);
            COND_MI:     cond_true = result[WIDTH-1];
            COND_PL:     cond_true = ~result[WIDTH-1];
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - registered ARM-format ALU with CARRY/SKIP flags; ALU_MUL_EN adds shift-add multiply
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      instruction,
    input  logic [WIDTH-1:0] rddata,
    input  logic [WIDTH-1:0] rsdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluout,
    output logic             wen,
    output logic             carry,
    output logic             skip
);

    state_t           state;

    // Instruction in effect: live word when accepting, latched word while multiplying
    logic [15:0]      fin_ir;
    logic             in_mul;
    logic             go_mul;
    logic             mul_last;
    logic [WIDTH-1:0] mul_res;
    logic             mul_cout;

    logic             arm;
    logic [1:0]       cin_sel;
    logic [3:0]       cond;
    logic             cw;
    logic [2:0]       op;
    logic             cin;
    logic             impl;
    logic [WIDTH:0]   sum;

    logic [WIDTH-1:0] fin_result;
    logic             fin_cout;
    logic             fin_ok;
    logic             fin_fire;
    logic             cond_true;

`ifdef ALU_MUL_EN
    logic [15:0]        ir_q;
    logic [WIDTH-1:0]   rd_q;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     mul_add;
    logic [CNT_W-1:0]   cnt;

    assign in_mul   = (state == S_MUL);
    assign fin_ir   = in_mul ? ir_q : instruction;
    assign go_mul   = (instruction[6:4] == OP_MUL);
    assign mul_last = in_mul && (cnt == CNT_W'(WIDTH - 1));

    // One shift-add step: upper half accumulates rd when the multiplier LSB is set
    always_comb begin
        mul_add = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, rd_q} : '0);
    end

    assign prod_next = {mul_add, prod[WIDTH-1:1]};
    assign mul_res   = prod_next[WIDTH-1:0];
    assign mul_cout  = |prod_next[2*WIDTH-1:WIDTH];

    // Latch the instruction and operands on accept, then iterate one bit per MUL cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q <= '0;
            rd_q <= '0;
            prod <= '0;
            cnt  <= '0;
        end else if (state == S_IDLE && start) begin
            ir_q <= instruction;
            rd_q <= rddata;
            prod <= {{WIDTH{1'b0}}, rsdata};
            cnt  <= '0;
        end else if (in_mul) begin
            prod <= prod_next;
            cnt  <= cnt + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;

    assign unused_cnt_w = '0;
    assign in_mul       = 1'b0;
    assign fin_ir       = instruction;
    assign go_mul       = 1'b0;
    assign mul_last     = 1'b0;
    assign mul_res      = '0;
    assign mul_cout     = 1'b0;
`endif

    assign arm     = (fin_ir[15:14] == CODE_ARM);
    assign cin_sel = fin_ir[13:12];
    assign cond    = fin_ir[11:8];
    assign cw      = fin_ir[7];
    assign op      = fin_ir[6:4];

    logic unused_ok;
    assign unused_ok = &{1'b0, fin_ir[3:0]};

    // Carry-in select; the flag source is the registered CARRY, not this cycle's carry-out
    always_comb begin
        cin = 1'b0;
        case (cin_sel)
            CIN_ZERO:  cin = 1'b0;
            CIN_ONE:   cin = 1'b1;
            CIN_CARRY: cin = carry;
            CIN_MSB:   cin = rsdata[WIDTH-1];
            default:   cin = 1'b0;
        endcase
    end

    // Single-cycle datapath at WIDTH+1 bits; the top bit is the carry-out
    always_comb begin
        sum  = '0;
        impl = 1'b1;
        case (op)
            OP_ADD: sum = {1'b0, rddata} + {1'b0, rsdata} + {{WIDTH{1'b0}}, cin};
            OP_SUB: sum = {1'b0, rddata} + {1'b0, ~rsdata} + {{WIDTH{1'b0}}, cin};
            OP_MOV: sum = {1'b0, rsdata} + {{WIDTH{1'b0}}, cin};
            OP_XSR: sum = {rsdata[0], cin, rsdata[WIDTH-1:1]};
            OP_AND: sum = {1'b0, rddata & rsdata};
            OP_OR:  sum = {1'b0, rddata | rsdata};
            OP_MUL, OP_RSV: begin
                sum  = '0;
                impl = 1'b0;
            end
            default: begin
                sum  = '0;
                impl = 1'b0;
            end
        endcase
    end

    assign fin_result = in_mul ? mul_res : sum[WIDTH-1:0];
    assign fin_cout   = in_mul ? mul_cout : sum[WIDTH];
    assign fin_ok     = arm & (in_mul | impl);
    assign fin_fire   = (state == S_IDLE && start && !go_mul) || mul_last;

    alu_cond_eval #(
        .WIDTH     (WIDTH)
    ) u_cond_eval (
        .cond      (cond),
        .result    (fin_result),
        .carry_out (fin_cout),
        .cond_true (cond_true)
    );

    // Control FSM; results and flags are registered on the edge that enters DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            wen    <= 1'b0;
            aluout <= '0;
            carry  <= 1'b0;
            skip   <= 1'b0;
        end else begin
            done <= 1'b0;
            wen  <= 1'b0;
            if (fin_fire) begin
                done   <= 1'b1;
                wen    <= fin_ok;
                aluout <= fin_result;
                if (fin_ok) begin
                    skip <= cond_true;
                    if (cw) begin
                        carry <= fin_cout;
                    end
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= go_mul ? S_MUL : S_DONE;
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    if (mul_last) begin
                        state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - directed bench for alu_seq_unit; multiply steps follow ALU_MUL_EN
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] instruction;
    logic [15:0] rddata;
    logic [15:0] rsdata;
    logic        busy;
    logic        done;
    logic [15:0] aluout;
    logic        wen;
    logic        carry;
    logic        skip;

    int total = 0;
    int bad   = 0;

    alu_seq_unit #(
        .WIDTH       (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .rddata      (rddata),
        .rsdata      (rsdata),
        .busy        (busy),
        .done        (done),
        .aluout      (aluout),
        .wen         (wen),
        .carry       (carry),
        .skip        (skip)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ins(input logic [1:0] code, input logic [1:0] ci,
                                        input logic [3:0] cnd, input logic cwb,
                                        input logic [2:0] o);
        return {code, ci, cnd, cwb, o, 4'b0000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_op(input string tag, input logic chk_out, input logic [15:0] exp_out,
                          input logic exp_wen, input logic exp_c, input logic exp_s);
        chk($sformatf("%s.done", tag), {31'd0, done}, 32'd1);
        if (chk_out) chk($sformatf("%s.aluout", tag), {16'd0, aluout}, {16'd0, exp_out});
        chk($sformatf("%s.wen", tag), {31'd0, wen}, {31'd0, exp_wen});
        chk($sformatf("%s.carry", tag), {31'd0, carry}, {31'd0, exp_c});
        chk($sformatf("%s.skip", tag), {31'd0, skip}, {31'd0, exp_s});
    endtask

    task automatic launch(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        instruction = i;
        rddata      = a;
        rsdata      = b;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic busy_ok;
        logic any_done;

        reset       = 1'b1;
        start       = 1'b0;
        instruction = '0;
        rddata      = '0;
        rsdata      = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst.busy",   {31'd0, busy},   32'd0);
        chk("rst.done",   {31'd0, done},   32'd0);
        chk("rst.wen",    {31'd0, wen},    32'd0);
        chk("rst.aluout", {16'd0, aluout}, 32'd0);
        chk("rst.carry",  {31'd0, carry},  32'd0);
        chk("rst.skip",   {31'd0, skip},   32'd0);
        reset = 1'b0;

        // ADD FFFF+0001: wraps to 0 with carry-out, COND CS true
        launch(ins(2'b11, 2'b00, 4'b0010, 1'b1, 3'b000), 16'hFFFF, 16'h0001);
        chk_op("add1", 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);
        chk("add1.busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("add1.done_drop", {31'd0, done}, 32'd0);
        chk("add1.busy_drop", {31'd0, busy}, 32'd0);
        chk("add1.wen_drop",  {31'd0, wen},  32'd0);

        // SUB 5-5 with CW=0: carry holds 1, COND EQ true
        launch(ins(2'b11, 2'b01, 4'b0100, 1'b0, 3'b001), 16'h0005, 16'h0005);
        chk_op("sub1", 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);

        // MOV 1234: carry-out 0 clears carry, COND NE true
        launch(ins(2'b11, 2'b00, 4'b0101, 1'b1, 3'b010), 16'h0000, 16'h1234);
        chk_op("mov1", 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);

        // XSR with cin = rs MSB: 8001 -> C000, carry-out rs[0]=1, COND PL false
        launch(ins(2'b11, 2'b11, 4'b0111, 1'b1, 3'b011), 16'h0000, 16'h8001);
        chk_op("xsr1", 1'b1, 16'hC000, 1'b1, 1'b1, 1'b0);

        // MOV 7FFF with cin from CARRY flag (1): 8000, COND MI true
        launch(ins(2'b11, 2'b10, 4'b0110, 1'b1, 3'b010), 16'h0000, 16'h7FFF);
        chk_op("movc", 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);

        // ADD 8000+8000: 0 with carry-out, COND CC false
        launch(ins(2'b11, 2'b00, 4'b0011, 1'b1, 3'b000), 16'h8000, 16'h8000);
        chk_op("add2", 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);

        // AND: carry-out forced 0, COND always
        launch(ins(2'b11, 2'b01, 4'b0001, 1'b1, 3'b101), 16'hF0F0, 16'h3C3C);
        chk_op("and1", 1'b1, 16'h3030, 1'b1, 1'b0, 1'b1);

        // OR with COND never
        launch(ins(2'b11, 2'b00, 4'b0000, 1'b0, 3'b110), 16'h00F0, 16'h0F00);
        chk_op("or1", 1'b1, 16'h0FF0, 1'b1, 1'b0, 1'b0);

        // COND 1001 is never even though carry-out is set
        launch(ins(2'b11, 2'b00, 4'b1001, 1'b1, 3'b000), 16'hFFFF, 16'h0002);
        chk_op("cnd1x", 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);

        // SUB 3-1, CW=0, COND always
        launch(ins(2'b11, 2'b01, 4'b0001, 1'b0, 3'b001), 16'h0003, 16'h0001);
        chk_op("sub2", 1'b1, 16'h0002, 1'b1, 1'b1, 1'b1);

        // Non-ARM code: completes, no write, flags untouched
        launch(ins(2'b10, 2'b00, 4'b0000, 1'b1, 3'b101), 16'h0000, 16'h0000);
        chk_op("noarm", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

        // Reserved OP: result 0, no write, flags untouched
        launch(ins(2'b11, 2'b00, 4'b0000, 1'b1, 3'b111), 16'h0001, 16'h0001);
        chk_op("rsv", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);

        // start held into the busy cycle must not launch a second op
        @(negedge clk);
        instruction = ins(2'b11, 2'b00, 4'b0001, 1'b1, 3'b000);
        rddata      = 16'h0001;
        rsdata      = 16'h0001;
        start       = 1'b1;
        @(negedge clk);
        chk_op("hold", 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("hold.done2", {31'd0, done}, 32'd0);
        chk("hold.busy2", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("hold.done3", {31'd0, done}, 32'd0);

`ifdef ALU_MUL_EN
        // Clear flags so the multiply's flag update is observable
        launch(ins(2'b11, 2'b00, 4'b0000, 1'b1, 3'b010), 16'h0000, 16'h0001);
        chk_op("mov0", 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);

        // 0100*0100 = 10000: low half 0, overflow -> carry; start mid-op ignored
        launch(ins(2'b11, 2'b00, 4'b0100, 1'b1, 3'b100), 16'h0100, 16'h0100);
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == 5) begin
                instruction = ins(2'b11, 2'b00, 4'b0001, 1'b1, 3'b000);
                start       = 1'b1;
            end
            if (cyc == 6) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("mul1.latency", cyc, 32'd17);
        chk("mul1.busy_held", {31'd0, busy_ok}, 32'd1);
        chk("mul1.busy", {31'd0, busy}, 32'd1);
        chk_op("mul1", 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);
        any_done = 1'b0;
        @(negedge clk);
        chk("mul1.busy_drop", {31'd0, busy}, 32'd0);
        repeat (5) begin
            if (done === 1'b1) any_done = 1'b1;
            @(negedge clk);
        end
        chk("mul1.no_extra_done", {31'd0, any_done}, 32'd0);

        // 0012*0034 = 03A8, no overflow
        launch(ins(2'b11, 2'b01, 4'b0101, 1'b1, 3'b100), 16'h0012, 16'h0034);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("mul2.latency", cyc, 32'd17);
        chk_op("mul2", 1'b1, 16'h03A8, 1'b1, 1'b0, 1'b1);

        // Reset at cycle 5 of a multiply aborts it
        launch(ins(2'b11, 2'b00, 4'b0001, 1'b1, 3'b100), 16'h0100, 16'h0100);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mulrst.busy",   {31'd0, busy},   32'd0);
        chk("mulrst.done",   {31'd0, done},   32'd0);
        chk("mulrst.carry",  {31'd0, carry},  32'd0);
        chk("mulrst.skip",   {31'd0, skip},   32'd0);
        chk("mulrst.aluout", {16'd0, aluout}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        any_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) any_done = 1'b1;
        end
        chk("mulrst.no_done", {31'd0, any_done}, 32'd0);
`else
        // OP100 without the multiplier: one cycle, result 0, no write, flags kept
        launch(ins(2'b11, 2'b00, 4'b0000, 1'b1, 3'b100), 16'h0003, 16'h0003);
        chk_op("mulx", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("mulx.busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("mulx.busy_drop", {31'd0, busy}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
